// File: rtl/bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter_if
//  Description : Bundle of the fetch, data and memory-port signals that
//                surround the two-master bus arbiter. The slave modport is
//                the arbiter's view; the master modport is the view of the
//                environment that issues requests and models memory.
//  Revision    : 1.0  initial release
// ============================================================================
interface bus_arbiter_if;

  // Instruction-fetch side (read only)
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;

  // Load/store side
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;

  // Shared memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  // Timeout indication
  logic        err;

  // Arbiter view
  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ready,
    output i_rdata, i_ack,
    output d_rdata, d_ack,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output err
  );

  // Requester / memory-model view
  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ready,
    input  i_rdata, i_ack,
    input  d_rdata, d_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  err
  );

endinterface : bus_arbiter_if
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_arbiter
//  Description : Arbitrates an instruction-fetch port and a load/store port
//                onto a single memory port. One transaction is in flight at
//                a time (IDLE -> BUSY -> ACK). Ties are broken in favour of
//                the side that was not granted last. A granted transaction
//                that sees no mem_ready for TIMEOUT busy cycles is aborted
//                with an err pulse alongside the requester's ack.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_arbiter #(
  parameter int TIMEOUT = 16   // busy cycles before abort, 2..255
) (
  input  wire logic     clk,
  input  wire logic     rst,
  bus_arbiter_if.slave  bus
);

  // Last busy-cycle count value before the abort fires. The counter holds
  // the number of already-elapsed busy cycles without mem_ready, so the
  // abort happens on the TIMEOUT-th busy edge.
  localparam logic [7:0] c_wait_last = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t     r_state;
  logic       r_last_data;   // 1 = data side was granted most recently
  logic       r_grant_data;  // side owning the current transaction
  logic       r_store;       // current transaction is a store
  logic [7:0] r_wait_cnt;    // busy cycles elapsed without mem_ready

  logic       w_any_req;
  logic       w_pick_data;

  // Winner selection: a lone requester wins; on a tie the side that did not
  // win last time gets the bus.
  always_comb begin
    w_any_req   = bus.i_req | bus.d_req;
    w_pick_data = bus.d_req & (~bus.i_req | ~r_last_data);
  end

  // Transaction FSM; every output is a register so reset clears them at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_last_data   <= 1'b0;
      r_grant_data  <= 1'b0;
      r_store       <= 1'b0;
      r_wait_cnt    <= 8'd0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 32'd0;
      bus.mem_wdata <= 32'd0;
      bus.i_ack     <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.i_rdata   <= 32'd0;
      bus.d_rdata   <= 32'd0;
      bus.err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          bus.i_ack <= 1'b0;
          bus.d_ack <= 1'b0;
          bus.err   <= 1'b0;
          if (w_any_req) begin
            r_state      <= S_BUSY;
            r_grant_data <= w_pick_data;
            r_last_data  <= w_pick_data;
            r_wait_cnt   <= 8'd0;
            bus.mem_req  <= 1'b1;
            if (w_pick_data) begin
              r_store       <= bus.d_we;
              bus.mem_we    <= bus.d_we;
              bus.mem_addr  <= bus.d_addr;
              bus.mem_wdata <= bus.d_wdata;
            end else begin
              // Fetches are always reads with no write data.
              r_store       <= 1'b0;
              bus.mem_we    <= 1'b0;
              bus.mem_addr  <= bus.i_addr;
              bus.mem_wdata <= 32'd0;
            end
          end
        end

        S_BUSY: begin
          if (bus.mem_ready) begin
            // Normal completion takes priority over a coincident timeout.
            r_state     <= S_ACK;
            bus.mem_req <= 1'b0;
            if (r_grant_data) begin
              bus.d_ack <= 1'b1;
              if (!r_store) begin
                bus.d_rdata <= bus.mem_rdata;
              end
            end else begin
              bus.i_ack   <= 1'b1;
              bus.i_rdata <= bus.mem_rdata;
            end
          end else if (r_wait_cnt == c_wait_last) begin
            // Abort: complete towards the requester with err and zero data.
            r_state     <= S_ACK;
            bus.mem_req <= 1'b0;
            bus.err     <= 1'b1;
            if (r_grant_data) begin
              bus.d_ack <= 1'b1;
              if (!r_store) begin
                bus.d_rdata <= 32'd0;
              end
            end else begin
              bus.i_ack   <= 1'b1;
              bus.i_rdata <= 32'd0;
            end
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end

        S_ACK: begin
          // Requests are ignored here; a held request re-arbitrates in IDLE.
          r_state   <= S_IDLE;
          bus.i_ack <= 1'b0;
          bus.d_ack <= 1'b0;
          bus.err   <= 1'b0;
        end

        default: begin
          r_state     <= S_IDLE;
          bus.mem_req <= 1'b0;
          bus.i_ack   <= 1'b0;
          bus.d_ack   <= 1'b0;
          bus.err     <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // Only one completion may be signalled at a time.
  a_ack_excl : assert property (@(posedge clk) disable iff (rst)
    !(bus.i_ack && bus.d_ack));

  // err never appears without the ack of the aborted transaction.
  a_err_ack : assert property (@(posedge clk) disable iff (rst)
    bus.err |-> (bus.i_ack || bus.d_ack));

  // Acks are single-cycle pulses.
  a_i_pulse : assert property (@(posedge clk) disable iff (rst)
    bus.i_ack |=> !bus.i_ack);
  a_d_pulse : assert property (@(posedge clk) disable iff (rst)
    bus.d_ack |=> !bus.d_ack);

  // Memory command is frozen while waiting for mem_ready.
  a_mem_hold : assert property (@(posedge clk) disable iff (rst)
    (bus.mem_req && !bus.mem_ready) |=>
      (!bus.mem_req || $stable({bus.mem_we, bus.mem_addr, bus.mem_wdata})));
`endif

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_arbiter
//  Description : Self-checking bench for bus_arbiter. A table of per-cycle
//                input/expected-output records covers grants, ties, loads,
//                stores and ignored mem_ready; directed sequences cover
//                alternation, timeout, ready-on-last-cycle and mid-busy reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bus_arbiter_if bus ();

  bus_arbiter #(.TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        e_mem_req;
    logic        e_mem_we;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic        e_i_ack;
    logic        e_d_ack;
    logic        e_err;
    logic [31:0] e_i_rdata;
    logic [31:0] e_d_rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia,
    input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
    input logic rdy, input logic [31:0] rd,
    input logic emr, input logic emw, input logic [31:0] ema, input logic [31:0] emd,
    input logic eia, input logic eda, input logic eer,
    input logic [31:0] eir, input logic [31:0] edr);
    vec_t v;
    v.i_req = ir;  v.i_addr = ia;
    v.d_req = dr;  v.d_we = dw; v.d_addr = da; v.d_wdata = dwd;
    v.mem_ready = rdy; v.mem_rdata = rd;
    v.e_mem_req = emr; v.e_mem_we = emw; v.e_mem_addr = ema; v.e_mem_wdata = emd;
    v.e_i_ack = eia; v.e_d_ack = eda; v.e_err = eer;
    v.e_i_rdata = eir; v.e_d_rdata = edr;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_req = 1'b0; bus.i_addr = 32'd0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'd0; bus.d_wdata = 32'd0;
    bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();

    // ---- Reset state --------------------------------------------------
    edge_sample();
    edge_sample();
    chk("rst_mem_req", 0, 32'(bus.mem_req), 32'd0);
    chk("rst_i_ack",   0, 32'(bus.i_ack),   32'd0);
    chk("rst_d_ack",   0, 32'(bus.d_ack),   32'd0);
    chk("rst_err",     0, 32'(bus.err),     32'd0);
    chk("rst_i_rdata", 0, bus.i_rdata,      32'd0);
    chk("rst_d_rdata", 0, bus.d_rdata,      32'd0);
    chk("rst_mem_addr",0, bus.mem_addr,     32'd0);
    rst = 1'b0;

    // ---- Table-driven sequences ---------------------------------------
    //          ir ia           dr dw da            dwd           rdy rd
    //          emr emw ema     emd           eia eda eer eir           edr
    // Tie right after reset: store wins, fetch follows.
    vecs.push_back(mk(1, 32'h200, 1, 1, 32'h100, 32'hDEAD_BEEF, 0, 32'h0,
                      1, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 32'h200, 1, 1, 32'h100, 32'hDEAD_BEEF, 1, 32'h1234_5678,
                      0, 0, 32'h0, 32'h0, 0, 1, 0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 32'h200, 0, 0, 32'h0, 32'h0, 0, 32'h0,
                      0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 32'h200, 0, 0, 32'h0, 32'h0, 0, 32'h0,
                      1, 0, 32'h200, 32'h0, 0, 0, 0, 32'h0, 32'h0));
    vecs.push_back(mk(1, 32'h200, 0, 0, 32'h0, 32'h0, 1, 32'hCAFE_0001,
                      0, 0, 32'h0, 32'h0, 1, 0, 0, 32'hCAFE_0001, 32'h0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 32'hFFFF_FFFF,
                      0, 0, 32'h0, 32'h0, 0, 0, 0, 32'hCAFE_0001, 32'h0));
    // mem_ready with no request outstanding is ignored.
    vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 32'hFFFF_FFFF,
                      0, 0, 32'h0, 32'h0, 0, 0, 0, 32'hCAFE_0001, 32'h0));
    // Single fetch, ready on second busy cycle.
    vecs.push_back(mk(1, 32'h40, 0, 0, 32'h0, 32'h0, 0, 32'h0,
                      1, 0, 32'h40, 32'h0, 0, 0, 0, 32'hCAFE_0001, 32'h0));
    vecs.push_back(mk(1, 32'h40, 0, 0, 32'h0, 32'h0, 0, 32'h0,
                      1, 0, 32'h40, 32'h0, 0, 0, 0, 32'hCAFE_0001, 32'h0));
    vecs.push_back(mk(1, 32'h40, 0, 0, 32'h0, 32'h0, 1, 32'h2408_0005,
                      0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h2408_0005, 32'h0));
    vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0,
                      0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h2408_0005, 32'h0));
    // Load issued while mem_ready is already high: ready ignored in IDLE.
    vecs.push_back(mk(0, 32'h0, 1, 0, 32'h300, 32'h1111_1111, 1, 32'h9999_9999,
                      1, 0, 32'h300, 32'h1111_1111, 0, 0, 0, 32'h2408_0005, 32'h0));
    vecs.push_back(mk(0, 32'h0, 1, 0, 32'h300, 32'h1111_1111, 1, 32'h55AA_55AA,
                      0, 0, 32'h0, 32'h0, 0, 1, 0, 32'h2408_0005, 32'h55AA_55AA));
    vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0,
                      0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h2408_0005, 32'h55AA_55AA));
    // Store leaves d_rdata untouched.
    vecs.push_back(mk(0, 32'h0, 1, 1, 32'h304, 32'h0BAD_F00D, 0, 32'h0,
                      1, 1, 32'h304, 32'h0BAD_F00D, 0, 0, 0, 32'h2408_0005, 32'h55AA_55AA));
    vecs.push_back(mk(0, 32'h0, 1, 1, 32'h304, 32'h0BAD_F00D, 1, 32'h1357_2468,
                      0, 0, 32'h0, 32'h0, 0, 1, 0, 32'h2408_0005, 32'h55AA_55AA));
    vecs.push_back(mk(0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 32'h0,
                      0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h2408_0005, 32'h55AA_55AA));

    for (int i = 0; i < vecs.size(); i++) begin
      bus.i_req     = vecs[i].i_req;
      bus.i_addr    = vecs[i].i_addr;
      bus.d_req     = vecs[i].d_req;
      bus.d_we      = vecs[i].d_we;
      bus.d_addr    = vecs[i].d_addr;
      bus.d_wdata   = vecs[i].d_wdata;
      bus.mem_ready = vecs[i].mem_ready;
      bus.mem_rdata = vecs[i].mem_rdata;
      edge_sample();
      chk("mem_req", i, 32'(bus.mem_req), 32'(vecs[i].e_mem_req));
      if (vecs[i].e_mem_req) begin
        chk("mem_we",    i, 32'(bus.mem_we), 32'(vecs[i].e_mem_we));
        chk("mem_addr",  i, bus.mem_addr,    vecs[i].e_mem_addr);
        chk("mem_wdata", i, bus.mem_wdata,   vecs[i].e_mem_wdata);
      end
      chk("i_ack",   i, 32'(bus.i_ack), 32'(vecs[i].e_i_ack));
      chk("d_ack",   i, 32'(bus.d_ack), 32'(vecs[i].e_d_ack));
      chk("err",     i, 32'(bus.err),   32'(vecs[i].e_err));
      chk("i_rdata", i, bus.i_rdata,    vecs[i].e_i_rdata);
      chk("d_rdata", i, bus.d_rdata,    vecs[i].e_d_rdata);
    end
    idle_inputs();

    // ---- Alternation after a fresh reset: D, I, D, I ------------------
    rst = 1'b1;
    edge_sample();
    rst = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h500;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h600;
    bus.mem_ready = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      bus.mem_rdata = 32'hA000_0000 + 32'(e);
      edge_sample();
      chk("alt_d_ack", e, 32'(bus.d_ack), 32'((e % 6) == 2));
      chk("alt_i_ack", e, 32'(bus.i_ack), 32'((e % 6) == 5));
      if ((e % 6) == 1) chk("alt_addr_d", e, bus.mem_addr, 32'h600);
      if ((e % 6) == 4) chk("alt_addr_i", e, bus.mem_addr, 32'h500);
      if ((e % 6) == 2) chk("alt_d_rdata", e, bus.d_rdata, 32'hA000_0000 + 32'(e));
      if ((e % 6) == 5) chk("alt_i_rdata", e, bus.i_rdata, 32'hA000_0000 + 32'(e));
    end
    idle_inputs();

    // ---- Timeout on a load --------------------------------------------
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h700;
    edge_sample();
    chk("to_start", 0, 32'(bus.mem_req), 32'd1);
    for (int j = 1; j <= 16; j++) begin
      edge_sample();
      chk("to_mem_req", j, 32'(bus.mem_req), 32'(j < 16));
      chk("to_d_ack",   j, 32'(bus.d_ack),   32'(j == 16));
      chk("to_err",     j, 32'(bus.err),     32'(j == 16));
      if (j == 16) chk("to_d_rdata", j, bus.d_rdata, 32'h0);
    end
    bus.d_req = 1'b0;
    edge_sample();
    chk("to_after_ack", 0, 32'(bus.d_ack), 32'd0);
    chk("to_after_err", 0, 32'(bus.err),   32'd0);

    // ---- Ready on the last allowed busy cycle: normal completion ------
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h704;
    bus.mem_rdata = 32'h77;
    edge_sample();
    for (int j = 1; j <= 16; j++) begin
      bus.mem_ready = (j == 16);
      edge_sample();
      chk("late_mem_req", j, 32'(bus.mem_req), 32'(j < 16));
      chk("late_d_ack",   j, 32'(bus.d_ack),   32'(j == 16));
      chk("late_err",     j, 32'(bus.err),     32'd0);
      if (j == 16) chk("late_d_rdata", j, bus.d_rdata, 32'h77);
    end
    idle_inputs();
    edge_sample();

    // ---- Reset in the middle of a busy fetch --------------------------
    bus.i_req = 1'b1; bus.i_addr = 32'h800;
    edge_sample();
    chk("mid_busy", 0, 32'(bus.mem_req), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_mem_req", 0, 32'(bus.mem_req), 32'd0);
    chk("mid_rst_i_ack",   0, 32'(bus.i_ack),   32'd0);
    chk("mid_rst_d_rdata", 0, bus.d_rdata,      32'd0);
    edge_sample();
    chk("mid_rst_hold", 0, 32'(bus.mem_req), 32'd0);
    chk("mid_rst_ack",  0, 32'(bus.i_ack),   32'd0);
    rst = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h900; bus.d_wdata = 32'h1234;
    edge_sample();
    chk("post_rst_req",  0, 32'(bus.mem_req), 32'd1);
    chk("post_rst_we",   0, 32'(bus.mem_we),  32'd1);
    chk("post_rst_addr", 0, bus.mem_addr,     32'h900);
    bus.mem_ready = 1'b1;
    edge_sample();
    chk("post_rst_d_ack", 0, 32'(bus.d_ack), 32'd1);
    chk("post_rst_i_ack", 0, 32'(bus.i_ack), 32'd0);
    idle_inputs();
    edge_sample();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_bus_arbiter
`default_nettype wire

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 16, max cycles a granted transaction waits for mem_ready before abort (range 2..255).
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 i_req  input  1  instruction-fetch read request, held until i_ack.
REQ-005 i_addr  input  32  fetch address, stable while i_req high.
REQ-006 i_rdata  output  32  fetch read data, valid in i_ack cycle.
REQ-007 i_ack  output  1  one-cycle completion pulse to fetch side.
REQ-008 d_req  input  1  load/store request, held until d_ack.
REQ-009 d_we  input  1  1 = store, 0 = load; stable while d_req high.
REQ-010 d_addr  input  32  data address.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_rdata  output  32  load data, valid in d_ack cycle.
REQ-013 d_ack  output  1  one-cycle completion pulse to data side.
REQ-014 mem_req  output  1  memory-port request, held until mem_ready or abort.
REQ-015 mem_we  output  1  memory write enable.
REQ-016 mem_addr  output  32  memory address.
REQ-017 mem_wdata  output  32  memory write data.
REQ-018 mem_rdata  input  32  memory read data, valid when mem_ready high.
REQ-019 mem_ready  input  1  memory completion, sampled only while mem_req high.
REQ-020 err  output  1  one-cycle timeout pulse, coincident with the aborted ack.

Function
REQ-021 The block SHALL implement states IDLE, BUSY, ACK; all outputs registered.
REQ-022 In IDLE, with any request sampled at edge N, it SHALL latch the winner's addr/we/wdata (fetch: we=0, wdata=0), enter BUSY, and assert mem_req from cycle N+1.
REQ-023 With only one request pending, that requester SHALL win.
REQ-024 With both pending, the requester NOT granted last SHALL win; last-grant flag resets to fetch, so data wins the first tie.
REQ-025 In BUSY, mem_req, mem_we, mem_addr, mem_wdata SHALL stay constant until the edge that samples mem_ready=1.
REQ-026 On that edge: mem_req deasserts, state goes to ACK, granted side's ack asserts for exactly one cycle; for reads, its rdata register loads mem_rdata.
REQ-027 Minimum request-to-ack latency SHALL be 3 cycles (mem_ready high in first BUSY cycle).
REQ-028 Store completion SHALL NOT modify d_rdata; each rdata output holds its last loaded value until its next read completes.
REQ-029 In ACK, requests SHALL be ignored; state returns to IDLE next edge, so a req held high past its ack cycle starts a new transaction.
REQ-030 A wait counter SHALL clear on BUSY entry and increment each BUSY cycle without mem_ready; when TIMEOUT BUSY cycles elapse without mem_ready, mem_req SHALL drop, state enters ACK, granted side's ack and err assert together, and its rdata loads 0.
REQ-031 mem_ready sampled high in the same edge the counter reaches TIMEOUT SHALL count as normal completion (no err).
REQ-032 mem_ready while mem_req is low SHALL be ignored.
REQ-033 i_ack and d_ack SHALL never be high in the same cycle; at most one transaction outstanding.

Reset
REQ-034 rst high SHALL immediately force state IDLE, last-grant = fetch, counter 0, and all outputs (mem_*, acks, rdata, err) to 0, abandoning any in-flight transaction without ack.
REQ-035 After rst falls, the first request SHALL be accepted at the first rising edge with rst low.

Verification
REQ-036 Single fetch: i_req=1, i_addr=0x0000_0040, mem_ready high 2nd BUSY cycle with mem_rdata=0x2408_0005 -> mem_req 2 cycles, i_ack at cycle 4, i_rdata=0x2408_0005, d_ack=0.
REQ-037 Tie after reset: i_req and d_req high same edge, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF -> data granted first, mem_we=1, d_rdata unchanged; fetch served next, no ack overlap.
REQ-038 Alternation: both reqs held continuously, ready immediate -> acks alternate D,I,D,I, one ack per 3 cycles.
REQ-039 Timeout: d_req load, mem_ready held 0 -> mem_req drops after 16 BUSY cycles, d_ack=err=1 same cycle, d_rdata=0; ready arriving exactly on 16th cycle -> no err.
REQ-040 Reset mid-BUSY: assert rst with mem_req=1 -> mem_req=0 without waiting for an edge, no ack; post-reset tie grants data.
